// File: rtl/fwd_hazard_unit_pkg.sv
// Shared types and helpers for the forwarding / load-use hazard unit.
// Tracking entries use a fixed maximum address width; narrower addresses are zero-extended.
package fwd_hazard_unit_pkg;

  localparam int FWD_SEL_RF = 0;
  localparam int REG_AW_MAX = 8;

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic                  memread;
    logic [REG_AW_MAX-1:0] rd;
  } trk_entry_t;

  typedef struct packed {
    logic                  use_rs1;
    logic                  use_rs2;
    logic [REG_AW_MAX-1:0] rs1;
    logic [REG_AW_MAX-1:0] rs2;
  } ex_src_t;

  function automatic bit params_ok(int reg_aw, int fwd_stages, int load_stage);
    return reg_aw >= 1 && reg_aw <= REG_AW_MAX &&
           fwd_stages >= 1 && fwd_stages <= 6 &&
           load_stage >= 1 && load_stage <= fwd_stages;
  endfunction

  function automatic logic is_producer(trk_entry_t e);
    return e.valid && e.regwrite && (e.rd != '0);
  endfunction

  function automatic logic loads_into(trk_entry_t e,
                                      logic [REG_AW_MAX-1:0] src,
                                      logic use_src);
    return is_producer(e) && e.memread && use_src &&
           (src != '0) && (e.rd == src);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_match.sv
// Priority match of one EX source against the producer stages.
// Nearest stage wins; zero selects the register file.
module fwd_match
  import fwd_hazard_unit_pkg::*;
#(
  parameter int FWD_STAGES = 2,
  parameter int SEL_W      = 2
) (
  input  logic                  src_en,
  input  logic [REG_AW_MAX-1:0] src,
  input  trk_entry_t            stage [1:FWD_STAGES],
  output logic [SEL_W-1:0]      sel
);

  always_comb begin
    sel = SEL_W'(FWD_SEL_RF);
    if (src_en && src != '0) begin
      for (int k = FWD_STAGES; k >= 1; k--) begin
        if (is_producer(stage[k]) && stage[k].rd == src)
          sel = SEL_W'(k);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding selects and load-use stall generation.
// Tracks EX plus FWD_STAGES producer stages behind it.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_STAGE = 2,
  parameter int SEL_W      = $clog2(FWD_STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              ex_flush,
  output logic [SEL_W-1:0]  fwd_a,
  output logic [SEL_W-1:0]  fwd_b,
  output logic              stall,
  output logic [31:0]       stall_count
);

  if (!params_ok(REG_AW, FWD_STAGES, LOAD_STAGE)) begin : g_bad_params
    $error("fwd_hazard_unit: parameter out of range");
  end

  logic [REG_AW_MAX-1:0] rs1_x, rs2_x;
  trk_entry_t            ex_d, ex_q;
  ex_src_t               src_d, src_q;
  trk_entry_t            prod_d [1:FWD_STAGES];
  trk_entry_t            prod_q [1:FWD_STAGES];
  logic [31:0]           cnt_d, cnt_q;
  logic                  load_hit;

  assign rs1_x = REG_AW_MAX'(id_rs1);
  assign rs2_x = REG_AW_MAX'(id_rs2);

  // Only loads still short of LOAD_STAGE can block the ID instruction.
  always_comb begin
    load_hit = 1'b0;
    if (LOAD_STAGE >= 2)
      load_hit = loads_into(ex_q, rs1_x, id_use_rs1) ||
                 loads_into(ex_q, rs2_x, id_use_rs2);
    for (int k = 1; k <= LOAD_STAGE - 2; k++)
      load_hit = load_hit ||
                 loads_into(prod_q[k], rs1_x, id_use_rs1) ||
                 loads_into(prod_q[k], rs2_x, id_use_rs2);
    stall = id_valid && !ex_flush && load_hit;
  end

  always_comb begin
    ex_d  = '0;
    src_d = '0;
    if (id_valid && !stall && !ex_flush) begin
      ex_d.valid    = 1'b1;
      ex_d.regwrite = id_regwrite;
      ex_d.memread  = id_memread;
      ex_d.rd       = REG_AW_MAX'(id_rd);
      src_d.use_rs1 = id_use_rs1;
      src_d.use_rs2 = id_use_rs2;
      src_d.rs1     = rs1_x;
      src_d.rs2     = rs2_x;
    end
    prod_d[1] = ex_q;
    for (int k = 2; k <= FWD_STAGES; k++)
      prod_d[k] = prod_q[k-1];
    cnt_d = cnt_q;
    if (stall && cnt_q != '1)
      cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q  <= '0;
      src_q <= '0;
      for (int k = 1; k <= FWD_STAGES; k++)
        prod_q[k] <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      src_q <= src_d;
      for (int k = 1; k <= FWD_STAGES; k++)
        prod_q[k] <= prod_d[k];
      cnt_q <= cnt_d;
    end
  end

  fwd_match #(
    .FWD_STAGES(FWD_STAGES),
    .SEL_W     (SEL_W)
  ) u_match_a (
    .src_en(ex_q.valid && src_q.use_rs1),
    .src   (src_q.rs1),
    .stage (prod_q),
    .sel   (fwd_a)
  );

  fwd_match #(
    .FWD_STAGES(FWD_STAGES),
    .SEL_W     (SEL_W)
  ) u_match_b (
    .src_en(ex_q.valid && src_q.use_rs2),
    .src   (src_q.rs2),
    .stage (prod_q),
    .sel   (fwd_b)
  );

  assign stall_count = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: default instance driven from a vector table,
// a deep instance (4 stages, load at 3) driven by hand sequences.
module tb_fwd_hazard_unit;

  typedef struct packed {
    logic       v;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       fl;
  } in_t;

  typedef struct {
    in_t        in;
    logic [2:0] a;
    logic [2:0] b;
    logic       s;
  } vec_t;

  typedef struct {
    int          dut;
    string       name;
    logic [2:0]  a;
    logic [2:0]  b;
    logic        s;
    logic        ce;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  in_t         in0 = '0;
  in_t         in1 = '0;
  logic [1:0]  a0, b0;
  logic        s0;
  logic [31:0] c0;
  logic [2:0]  a1, b1;
  logic        s1;
  logic [31:0] c1;

  int   checks = 0;
  int   failures = 0;
  exp_t exp_q[$];
  exp_t em;
  vec_t tbl[$];

  always #5 clk = ~clk;

  fwd_hazard_unit dut0 (
    .clk(clk), .reset(reset),
    .id_valid(in0.v), .id_rs1(in0.rs1), .id_rs2(in0.rs2),
    .id_use_rs1(in0.u1), .id_use_rs2(in0.u2),
    .id_rd(in0.rd), .id_regwrite(in0.rw), .id_memread(in0.mr),
    .ex_flush(in0.fl),
    .fwd_a(a0), .fwd_b(b0), .stall(s0), .stall_count(c0)
  );

  fwd_hazard_unit #(
    .FWD_STAGES(4), .LOAD_STAGE(3)
  ) dut1 (
    .clk(clk), .reset(reset),
    .id_valid(in1.v), .id_rs1(in1.rs1), .id_rs2(in1.rs2),
    .id_use_rs1(in1.u1), .id_use_rs2(in1.u2),
    .id_rd(in1.rd), .id_regwrite(in1.rw), .id_memread(in1.mr),
    .ex_flush(in1.fl),
    .fwd_a(a1), .fwd_b(b1), .stall(s1), .stall_count(c1)
  );

  task automatic cmp(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  // Scoreboard side: compare everything queued for this cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      em = exp_q.pop_front();
      if (em.dut == 0) begin
        cmp({em.name, ".fwd_a"}, {29'd0, 1'b0, a0}, {29'd0, em.a});
        cmp({em.name, ".fwd_b"}, {29'd0, 1'b0, b0}, {29'd0, em.b});
        cmp({em.name, ".stall"}, {31'd0, s0}, {31'd0, em.s});
        if (em.ce) cmp({em.name, ".count"}, c0, em.cnt);
      end else begin
        cmp({em.name, ".fwd_a"}, {29'd0, a1}, {29'd0, em.a});
        cmp({em.name, ".fwd_b"}, {29'd0, b1}, {29'd0, em.b});
        cmp({em.name, ".stall"}, {31'd0, s1}, {31'd0, em.s});
        if (em.ce) cmp({em.name, ".count"}, c1, em.cnt);
      end
    end
  end

  function automatic in_t mk(logic v, logic [4:0] rs1, logic [4:0] rs2,
                             logic u1, logic u2, logic [4:0] rd,
                             logic rw, logic mr, logic fl);
    return in_t'{v, rs1, rs2, u1, u2, rd, rw, mr, fl};
  endfunction

  task automatic step(int dut, string name, in_t v,
                      logic [2:0] a, logic [2:0] b, logic s,
                      logic ce, logic [31:0] cnt, logic r);
    exp_t e;
    @(posedge clk);
    #1;
    reset = r;
    in0 = (dut == 0) ? v : '0;
    in1 = (dut == 1) ? v : '0;
    e.dut = dut; e.name = name;
    e.a = a; e.b = b; e.s = s; e.ce = ce; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic add(in_t v, logic [2:0] a, logic [2:0] b, logic s);
    vec_t t;
    t.in = v; t.a = a; t.b = b; t.s = s;
    tbl.push_back(t);
  endtask

  initial begin
    in_t idle, lw7, use7, use7f, lw4, use4, lw9, use9;
    idle  = '0;
    lw7   = mk(1, 2, 0, 1, 0, 7, 1, 1, 0);
    use7  = mk(1, 1, 7, 1, 1, 9, 1, 0, 0);
    use7f = mk(1, 1, 7, 1, 1, 9, 1, 0, 1);
    lw4   = mk(1, 3, 0, 1, 0, 4, 1, 1, 0);
    use4  = mk(1, 4, 0, 1, 0, 11, 1, 0, 0);
    lw9   = mk(1, 1, 0, 1, 0, 9, 1, 1, 0);
    use9  = mk(1, 9, 2, 1, 1, 10, 1, 0, 0);

    add(mk(1, 1, 2, 1, 1, 5, 1, 0, 0), 0, 0, 0);
    add(mk(1, 5, 3, 1, 1, 6, 1, 0, 0), 0, 0, 0);
    add(idle, 1, 0, 0);
    add(mk(1, 1, 2, 1, 1, 5, 1, 0, 0), 0, 0, 0);
    add(mk(1, 1, 2, 1, 1, 5, 1, 0, 0), 0, 0, 0);
    add(mk(1, 6, 5, 1, 1, 7, 1, 0, 0), 0, 0, 0);
    add(mk(1, 3, 4, 1, 1, 0, 1, 0, 0), 0, 1, 0);
    add(mk(1, 0, 0, 1, 1, 8, 1, 0, 0), 0, 0, 0);
    add(idle, 0, 0, 0);
    add(lw7, 0, 0, 0);
    add(use7, 0, 0, 1);
    add(use7, 0, 0, 0);
    add(idle, 0, 2, 0);
    add(lw7, 0, 0, 0);
    add(use7f, 0, 0, 0);
    add(idle, 0, 0, 0);
    add(lw4, 0, 0, 0);
    add(mk(1, 4, 2, 0, 1, 10, 1, 0, 0), 0, 0, 0);
    add(idle, 0, 0, 0);
    add(lw4, 0, 0, 0);
    add(use4, 0, 0, 1);
    add(use4, 0, 0, 0);
    add(idle, 2, 0, 0);

    step(0, "rst0", idle, 0, 0, 0, 1, 0, 1);
    step(1, "rst1", idle, 0, 0, 0, 1, 0, 0);

    for (int i = 0; i < tbl.size(); i++)
      step(0, $sformatf("vec%0d", i), tbl[i].in,
           tbl[i].a, tbl[i].b, tbl[i].s, 0, 0, 0);
    step(0, "cnt0", idle, 0, 0, 0, 1, 2, 0);

    step(1, "d_lw",    lw9,  0, 0, 0, 0, 0, 0);
    step(1, "d_stl1",  use9, 0, 0, 1, 1, 0, 0);
    step(1, "d_stl2",  use9, 0, 0, 1, 1, 1, 0);
    step(1, "d_rel",   use9, 0, 0, 0, 1, 2, 0);
    step(1, "d_fwd3",  idle, 3, 0, 0, 1, 2, 0);
    step(1, "r_lw",    lw9,  0, 0, 0, 0, 0, 0);
    step(1, "r_stl1",  use9, 0, 0, 1, 1, 2, 0);
    step(1, "r_stl2",  use9, 0, 0, 1, 1, 3, 1);
    step(1, "r_after", use9, 0, 0, 0, 1, 0, 0);
    step(1, "r_empty", idle, 0, 0, 0, 1, 0, 0);

    @(posedge clk);
    #1;
    in0 = '0;
    in1 = '0;
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard: got %0d pending expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter REG_AW, default 5: register-address width.
REQ-002 Parameter FWD_STAGES, default 2: number of tracked producer stages past EX (stage 1 = EX/MEM, stage 2 = MEM/WB, ...); range 1..6.
REQ-003 Parameter LOAD_STAGE, default 2: first stage index whose result is forwardable for a load; range 1..FWD_STAGES.
REQ-004 Parameter SEL_W, default $clog2(FWD_STAGES+1): width of each forward select.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 id_valid  in  1  ID/decode stage holds a real instruction.
REQ-008 id_rs1, id_rs2  in  REG_AW  ID source addresses.
REQ-009 id_use_rs1, id_use_rs2  in  1  ID instruction actually reads that source.
REQ-010 id_rd  in  REG_AW; id_regwrite  in  1; id_memread  in  1  ID destination, write enable, load flag.
REQ-011 ex_flush  in  1  branch/jump taken in EX; kills the ID instruction.
REQ-012 fwd_a, fwd_b  out  SEL_W  EX operand source: 0 = register file, k = stage k result.
REQ-013 stall  out  1  hold PC and IF/ID; insert bubble into ID/EX.
REQ-014 stall_count  out  32  saturating count of stall cycles since reset.

Function
REQ-015 Unit SHALL keep a tracking pipeline stage[0..FWD_STAGES], stage[0] = EX; each entry holds valid, rd, regwrite, memread; stage[0] also holds rs1, rs2, use_rs1, use_rs2.
REQ-016 Every cycle, stage[k] SHALL load stage[k-1] for k>=1, regardless of stall.
REQ-017 stage[0] SHALL load the ID instruction when id_valid & !stall & !ex_flush; otherwise SHALL load a bubble (valid=0).
REQ-018 An entry SHALL count as producer only if valid & regwrite & rd != 0.
REQ-019 fwd_a SHALL be the smallest k in 1..FWD_STAGES with stage[k] producer and stage[k].rd == stage[0].rs1 and use_rs1; 0 if none or stage[0] invalid; fwd_b likewise for rs2. Nearest stage wins on multiple matches.
REQ-020 Forwarding outputs SHALL be combinational from the tracking registers (zero added latency).
REQ-021 stall SHALL assert combinationally when id_valid & !ex_flush and, for some k in 0..LOAD_STAGE-2, stage[k] is a producer with memread and rd equal to a used ID source.
REQ-022 With LOAD_STAGE=1, stall SHALL never assert.
REQ-023 ex_flush SHALL override stall (stall=0 when ex_flush=1).
REQ-024 A stalled instruction SHALL re-evaluate each cycle; stall releases exactly when the load reaches stage LOAD_STAGE-1 (one cycle for defaults, LOAD_STAGE-1 cycles generally).
REQ-025 stall_count SHALL increment by 1 on every cycle with stall=1 and hold at 32'hFFFF_FFFF.
REQ-026 id_rs* == 0 SHALL never cause stall or forwarding.

Reset
REQ-027 reset SHALL clear all stage valid bits and stall_count to 0; outputs then read fwd_a=fwd_b=0, stall=0.
REQ-028 reset asserted mid-stall SHALL drop stall on the following cycle and discard all tracked instructions.

Structure
REQ-029 Shared package SHALL hold the FWD_SEL_RF=0 constant, the tracking-entry struct, and parameter range checks.
REQ-030 One sub-module fwd_match (priority match of one source against all stages, returning SEL_W index) SHALL be instantiated twice.

Verification
REQ-031 add x5 (EX/MEM), consumer rs1=x5 in EX -> fwd_a=1, fwd_b=0.
REQ-032 x5 written by stages 1 and 2, consumer rs2=x5 -> fwd_b=1 (nearest wins); rd=x0 producer -> fwd=0.
REQ-033 lw x7 in EX, ID uses rs2=x7 -> stall=1 one cycle, bubble in EX, then fwd_b=2; stall_count=1.
REQ-034 Same load-use with ex_flush=1 -> stall=0, stage[0] bubble next cycle.
REQ-035 FWD_STAGES=4, LOAD_STAGE=3, lw x9 then dependent -> stall 2 cycles, then fwd=3.
REQ-036 reset during stall -> next cycle stall=0, fwd_a=fwd_b=0, stall_count=0.
